// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES active-low reset domains in order after a hold time,
// re-running the sequence on software, watchdog or external resets and recording the cause.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8
) (
    input  logic                  clk,
    input  logic                  rst_async,
    input  logic                  rst_sync_n,
    input  logic                  sw_rst_req,
    input  logic                  wdt_expire,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  seq_done,
    output logic [1:0]            rst_cause,
    output logic [7:0]            rst_count
);

    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
    localparam int unsigned IW      = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    abort;
    logic [1:0]              abort_cause;
    logic [NUM_STAGES-1:0]   next_stage;

    always_comb begin
        abort       = !rst_sync_n || wdt_expire || sw_rst_req;
        abort_cause = !rst_sync_n ? 2'b11 : (wdt_expire ? 2'b10 : 2'b01);
        // Shifting a one in keeps the stage vector a thermometer code by construction.
        next_stage  = (rst_stage_n << 1) | NUM_STAGES'(1);
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state       <= ASSERT;
            rst_stage_n <= '0;
            seq_done    <= 1'b0;
            rst_cause   <= 2'b00;
            rst_count   <= '0;
            cnt         <= '0;
            idx         <= '0;
        end else if (state == ASSERT) begin
            rst_stage_n <= '0;
            seq_done    <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            if (!abort) begin
                state <= HOLD;
            end
        end else if (abort) begin
            state       <= ASSERT;
            rst_stage_n <= '0;
            seq_done    <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            rst_cause   <= abort_cause;
            if (rst_count != 8'hFF) begin
                rst_count <= rst_count + 8'd1;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        rst_stage_n <= next_stage;
                        cnt         <= '0;
                        idx         <= IW'(1);
                        if (NUM_STAGES == 1) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        rst_stage_n <= next_stage;
                        cnt         <= '0;
                        idx         <= idx + IW'(1);
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the synchronized reset from the upstream reset synchronizer.
- Releases NUM_STAGES downstream reset domains in a fixed order: clocking/PLL logic first, then interconnect, then cores.
- Enforces a minimum hold time and a programmable gap between stage releases.
- Re-runs the full sequence on a software reset request or a watchdog expiry, and records the cause and number of warm resets.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (legal 1..16)
HOLD_CYCLES, 16, cycles all stages stay asserted after the sequence starts (legal >=1)
STAGE_GAP, 8, cycles between consecutive stage releases (legal >=1)

Ports:
clk  input  1  sequencer clock; same domain as rst_sync_n
rst_async  input  1  reset: asynchronous, active-low
rst_sync_n  input  1  synchronized active-low reset from the upstream synchronizer; already in the clk domain
sw_rst_req  input  1  software warm-reset request, level, clk domain
wdt_expire  input  1  watchdog expiry, level, clk domain
rst_stage_n  output  NUM_STAGES  per-stage active-low resets; bit 0 is released first
seq_done  output  1  high once every stage is released
rst_cause  output  2  cause of the last sequence: 00 POR, 01 SW, 10 WDT, 11 EXT (rst_sync_n low while rst_async high)
rst_count  output  8  saturating count of warm resets (SW, WDT and EXT causes)

Behaviour:
- All outputs are registered and glitch-free. The internal counter width is $clog2(max(HOLD_CYCLES,STAGE_GAP))+1.
- While rst_async=0, asynchronously:
  - state=ASSERT, rst_stage_n=0, seq_done=0, rst_cause=00, rst_count=0
  - stage index=0, counter=0
- States: ASSERT, HOLD, RELEASE, DONE.
- Abort condition (checked every cycle): rst_sync_n=0, wdt_expire=1 or sw_rst_req=1.
  - In HOLD, RELEASE or DONE, an abort at edge E moves the FSM to ASSERT at E.
  - At E: rst_stage_n<=0, seq_done<=0, counter and stage index cleared.
  - At E: rst_cause is updated with priority EXT(11) > WDT(10) > SW(01).
  - At E: rst_count increments by 1, saturating at 255.
- ASSERT:
  - All stages held low.
  - Stays in ASSERT while any abort condition is true, so level-held requests extend the reset. No further cause or count update while in ASSERT.
  - Exits to HOLD, counter=0, at the first edge with rst_sync_n=1, sw_rst_req=0 and wdt_expire=0. Call this edge E0.
- HOLD:
  - Counter increments each cycle.
  - At edge E0+HOLD_CYCLES: state=RELEASE, rst_stage_n[0]<=1, stage index=1, counter=0.
- RELEASE:
  - Counter increments each cycle.
  - When counter reaches STAGE_GAP-1: rst_stage_n[index]<=1, index increments, counter=0.
- Stage k release timing:
  - Stage k goes high at edge E0+HOLD_CYCLES+k*STAGE_GAP.
  - On the edge that releases stage NUM_STAGES-1: state=DONE and seq_done<=1 on that same edge.
  - If NUM_STAGES=1, HOLD goes directly to DONE at E0+HOLD_CYCLES.
- rst_stage_n is always a thermometer code: bit k high implies bits 0..k-1 high. A stage never goes high out of order, and never goes high during ASSERT or HOLD.
- DONE: all outputs hold until an abort condition or rst_async.
- Reset mid-operation:
  - An abort during HOLD or RELEASE drops every stage in the same edge and restarts from ASSERT. No partial-release state is retained.
  - rst_async has priority over everything and clears rst_cause and rst_count.
- Edge cases:
  - A request pulse of one cycle is enough to trigger a full sequence.
  - Simultaneous sw_rst_req and wdt_expire record WDT and count once.

Test Plan:
1. POR: rst_async low 5 cycles, then high, rst_sync_n high 2 cycles later (E0), defaults -> stage0..3 go high at E0+16/+24/+32/+40; seq_done at E0+40; rst_cause=00; rst_count=0.
2. SW warm reset: in DONE, pulse sw_rst_req for 1 cycle -> rst_stage_n=0000 and seq_done=0 at that edge; rst_cause=01; rst_count=1; sequence replays with the same offsets from the next edge.
3. Mid-sequence abort plus priority: assert sw_rst_req and wdt_expire together for 1 cycle when stages 0-1 are released -> all stages low at that edge; rst_cause=10; rst_count increments by exactly 1; full restart with no stage skipping.
4. Held request plus EXT: hold wdt_expire for 20 cycles -> stages stay low throughout and E0 is the first edge after it drops. Separately, drop rst_sync_n with rst_async high -> rst_cause=11.
5. Saturation: 260 SW requests each allowed to reach DONE -> rst_count reads 255 and stays there; then rst_async low -> rst_count=0 and rst_cause=00.
6. Parameter sweep (NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1) -> stage0 and seq_done high at E0+1. Thermometer-code assertion holds on every cycle for every sweep point.
